// File: rtl/tt_um_taghreed_eialsalman_ha_bist.sv
// rtl/tt_um_taghreed_eialsalman_ha_bist.sv - half adder with built-in self test sweep (optional fault injection via HA_FAULT_INJECT_EN)
module tt_um_taghreed_eialsalman_ha_bist #(
  parameter int PASSES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;        // op_q[0]=a, op_q[1]=b
  logic        sum_q, carry_q;
  logic        sum_d, carry_d;
  logic [2:0]  err_q, err_d;
  logic [1:0]  idx_q, idx_d;
  logic [5:0]  pass_q, pass_d;
  logic        start_q;
  logic        start_rise;
  logic        mode;
  logic [1:0]  expected;

  assign mode       = ui_in[3];
  assign start_rise = ui_in[2] & ~start_q;
  assign expected   = {idx_q[1] & idx_q[0], idx_q[1] ^ idx_q[0]};

  assign carry_d = op_q[0] & op_q[1];
`ifdef HA_FAULT_INJECT_EN
  // Fault only perturbs the a=b=1 case so one vector per sweep miscompares
  assign sum_d = (op_q[0] ^ op_q[1]) ^ (ui_in[4] & op_q[0] & op_q[1]);
  logic unused_ok;
  assign unused_ok = &{1'b0, ui_in[7:5], uio_in};
`else
  assign sum_d = op_q[0] ^ op_q[1];
  logic unused_ok;
  assign unused_ok = &{1'b0, ui_in[7:4], uio_in};
`endif

  // Next-state, counter and operand selection
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    err_d   = err_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (mode && start_rise) begin
          state_d = APPLY;
          idx_d   = 2'd0;
          pass_d  = 6'd0;
          err_d   = 3'd0;
        end
      end
      APPLY: begin
        if (!mode) state_d = IDLE;
        else       state_d = CHECK;
      end
      CHECK: begin
        if (!mode) begin
          state_d = IDLE;
        end else begin
          if ({carry_q, sum_q} != expected && err_q != 3'd7) err_d = err_q + 3'd1;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            pass_d = pass_q + 6'd1;
            if (pass_q + 6'd1 == 6'(PASSES)) state_d = DONE;
            else                             state_d = APPLY;
          end else begin
            state_d = APPLY;
          end
        end
      end
      DONE: begin
        if (!mode) begin
          state_d = IDLE;
        end else if (start_rise) begin
          state_d = APPLY;
          idx_d   = 2'd0;
          pass_d  = 6'd0;
          err_d   = 3'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Operands are loaded on entry to APPLY so the registered sum is ready in CHECK
    if (state_d == APPLY) op_d = idx_d;
    else if (!mode)       op_d = ui_in[1:0];
  end

  // State, counters, edge detector and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 2'd0;
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 3'd0;
      idx_q   <= 2'd0;
      pass_q  <= 6'd0;
      start_q <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      op_q    <= op_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      start_q <= ui_in[2];
    end
  end

  logic busy, done, pass;
  assign busy = (state_q == APPLY) || (state_q == CHECK);
  assign done = (state_q == DONE);
  assign pass = done && (err_q == 3'd0);

  assign uo_out  = {err_q, pass, done, busy, carry_q, sum_q};
  assign uio_out = {pass_q, idx_q};
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_taghreed_eialsalman_ha_bist.sv
// tb/tb_tt_um_taghreed_eialsalman_ha_bist.sv - directed self-checking bench for the half adder BIST
module tb_tt_um_taghreed_eialsalman_ha_bist;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  tt_um_taghreed_eialsalman_ha_bist #(.PASSES(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_run;
    @(negedge clk);
    ui_in[2] = 1'b0;
    ui_in[3] = 1'b1;
    @(negedge clk);
    ui_in[2] = 1'b1;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_uo_out: got %h expected 00", uo_out); end
    checks++;
    if (uio_out !== 8'h00) begin errors++; $display("FAIL reset_uio_out: got %h expected 00", uio_out); end
    checks++;
    if (uio_oe !== 8'hFF) begin errors++; $display("FAIL reset_uio_oe: got %h expected FF", uio_oe); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_manual;
    logic [1:0] vin [4];
    logic [1:0] vexp [4];
    vin[0] = 2'b11; vexp[0] = 2'b10;
    vin[1] = 2'b01; vexp[1] = 2'b01;
    vin[2] = 2'b10; vexp[2] = 2'b01;
    vin[3] = 2'b00; vexp[3] = 2'b00;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ui_in[3]   = 1'b0;
      ui_in[1:0] = vin[k];
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (uo_out[1:0] !== 2'b00) begin errors++; $display("FAIL manual_latency: got %b expected 00", uo_out[1:0]); end
      end
      @(negedge clk);
      checks++;
      if (uo_out[1:0] !== vexp[k]) begin errors++; $display("FAIL manual_%0d: got %b expected %b", k, uo_out[1:0], vexp[k]); end
    end
  endtask

  task automatic test_bist_clean;
    int busy_cnt;
    int bad_busy;
    int bad_uio;
    logic [7:0] exp_uio;
    busy_cnt = 0; bad_busy = 0; bad_uio = 0;
    start_run();
    for (int i = 1; i <= 33; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 2) ui_in[2] = 1'b0;
      if (uo_out[2]) busy_cnt++;
      checks++;
      if (uo_out[2] !== (i < 33) || uo_out[3] !== (i == 33)) begin
        errors++; bad_busy++;
        if (bad_busy < 4) $display("FAIL clean_busy_done edge %0d: got busy=%b done=%b", i, uo_out[2], uo_out[3]);
      end
      exp_uio = {6'((i - 1) / 8), 2'(((i - 1) / 2) % 4)};
      checks++;
      if (uio_out !== exp_uio) begin
        errors++; bad_uio++;
        if (bad_uio < 4) $display("FAIL clean_uio edge %0d: got %h expected %h", i, uio_out, exp_uio);
      end
    end
    checks++;
    if (busy_cnt != 32) begin errors++; $display("FAIL clean_busy_cycles: got %0d expected 32", busy_cnt); end
    checks++;
    if (uo_out[7:3] !== 5'b00011) begin errors++; $display("FAIL clean_result: got err=%0d pass=%b done=%b expected 0/1/1", uo_out[7:5], uo_out[4], uo_out[3]); end
    checks++;
    if (uio_out !== 8'h10) begin errors++; $display("FAIL clean_pass_count: got %h expected 10", uio_out); end
  endtask

  task automatic test_done_hold;
    repeat (3) @(negedge clk);
    checks++;
    if (uo_out[4:2] !== 3'b110 || uio_out !== 8'h10) begin
      errors++; $display("FAIL done_hold: got uo=%h uio=%h expected pass/done held, uio 10", uo_out, uio_out);
    end
  endtask

  task automatic test_fault;
    logic [2:0] exp_err;
    logic       exp_pass;
`ifdef HA_FAULT_INJECT_EN
    exp_err = 3'd4; exp_pass = 1'b0;
`else
    exp_err = 3'd0; exp_pass = 1'b1;
`endif
    ui_in[4] = 1'b1;
    start_run();
    for (int i = 1; i <= 33; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 2) ui_in[2] = 1'b0;
      if (i == 32) begin
        checks++;
        if (uo_out[3] !== 1'b0) begin errors++; $display("FAIL fault_early_done: got done=%b expected 0", uo_out[3]); end
      end
    end
    checks++;
    if (uo_out[3] !== 1'b1 || uo_out[4] !== exp_pass || uo_out[7:5] !== exp_err) begin
      errors++; $display("FAIL fault_result: got done=%b pass=%b err=%0d expected 1/%b/%0d", uo_out[3], uo_out[4], uo_out[7:5], exp_pass, exp_err);
    end
    ui_in[4] = 1'b0;
  endtask

  task automatic test_back_to_back_freeze;
    int bad;
    bad = 0;
    start_run();
    for (int i = 1; i <= 38; i++) begin
      ena      = !(i >= 10 && i <= 14);
      ui_in[2] = (i == 1) || (i >= 6);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (uo_out[3] !== (i == 38)) begin
        errors++; bad++;
        if (bad < 4) $display("FAIL freeze_done edge %0d: got done=%b expected %b", i, uo_out[3], (i == 38));
      end
    end
    ena = 1'b1;
    ui_in[2] = 1'b0;
    checks++;
    if (uo_out[4] !== 1'b1 || uio_out !== 8'h10) begin
      errors++; $display("FAIL freeze_result: got pass=%b uio=%h expected 1/10", uo_out[4], uio_out);
    end
  endtask

  task automatic test_abort;
    start_run();
    for (int i = 1; i <= 10; i++) begin
      if (i == 2) ui_in[2] = 1'b0;
      if (i == 10) ui_in[3] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (i == 9) begin
        checks++;
        if (uo_out[2] !== 1'b1) begin errors++; $display("FAIL abort_pre_busy: got %b expected 1", uo_out[2]); end
      end
    end
    checks++;
    if (uo_out[2] !== 1'b0 || uo_out[3] !== 1'b0 || uo_out[7:5] !== 3'd0) begin
      errors++; $display("FAIL abort_idle: got busy=%b done=%b err=%0d expected 0/0/0", uo_out[2], uo_out[3], uo_out[7:5]);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (uo_out[3:2] !== 2'b00) begin errors++; $display("FAIL abort_stays_idle: got %b expected 00", uo_out[3:2]); end
  endtask

  task automatic test_reset_midrun;
    int bad;
    bad = 0;
    start_run();
    repeat (7) begin
      @(posedge clk);
      @(negedge clk);
      ui_in[2] = 1'b0;
    end
    checks++;
    if (uo_out[2] !== 1'b1 || uio_out === 8'h00) begin
      errors++; $display("FAIL midrun_active: got uo=%h uio=%h expected busy and nonzero index", uo_out, uio_out);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'hFF) begin
      errors++; $display("FAIL midrun_reset: got uo=%h uio=%h oe=%h expected 00/00/FF", uo_out, uio_out, uio_oe);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_run();
    for (int i = 1; i <= 33; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 2) ui_in[2] = 1'b0;
      checks++;
      if (uo_out[3] !== (i == 33)) begin
        errors++; bad++;
        if (bad < 4) $display("FAIL fresh_run_done edge %0d: got %b expected %b", i, uo_out[3], (i == 33));
      end
    end
    checks++;
    if (uo_out[4] !== 1'b1) begin errors++; $display("FAIL fresh_run_pass: got %b expected 1", uo_out[4]); end
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    test_reset();
    test_manual();
    test_bist_clean();
    test_done_hold();
    test_fault();
    test_back_to_back_freeze();
    test_abort();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
